apb_master_arbiter: RTL and testbench

//  Shares one APB master port between NREQ local requesters and sequences each APB transfer.
//  The APB phases are IDLE -> SETUP -> ACCESS. The block drives the PRDATA/PREADY-side slave

---
 rtl/apb_master_arbiter_pkg.sv | 27 ++
 rtl/apb_master_arbiter_if.sv | 29 ++
 rtl/apb_master_arbiter_rr_arbiter.sv | 42 ++++
 rtl/apb_master_arbiter.sv | 158 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and helpers for the APB master arbiter slice.
//   state_t          : APB transfer phase (IDLE / SETUP / ACCESS)
//   STATE_W          : width of the state encoding
//   TIMEOUT_CYC_DEF  : default ACCESS wait-state limit (timeout build only)
//   log2_min1()      : index/counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package apb_arb_pkg;

  localparam int STATE_W         = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // A 1-entry pointer or counter still needs one flop to exist.
  function automatic int log2_min1(input int n);
    int r;
    r = (n <= 1) ? 1 : $clog2(n);
    return r;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
// APB bus bundle between the arbiter (master) and the slave.
//   PSEL, PENABLE, PWRITE, PADDR[AW], PWDATA[DW] : driven by the master
//   PRDATA[DW], PREADY, PSLVERR                  : driven by the slave
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set request bit at or
// after 'ptr', wrapping modulo NREQ.
//   req[NREQ]       : pending requests (already masked by the caller)
//   ptr[PW]         : search start position
//   grant[NREQ]     : one-hot grant, zero when nothing is requested
//   grant_idx[PW]   : index of the granted bit
//   grant_valid     : a grant was found
// ---------------------------------------------------------------------------
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PW  = log2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_valid
);

  logic [PW-1:0] idx;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr) + off) % NREQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB master port between NREQ requesters (round-robin) and
// sequences IDLE -> SETUP -> ACCESS for each transfer.
//   SYSCLK, PRESETN          : clock, async active-low reset
//   REQ, REQ_WRITE[NREQ]     : per-requester pending flag and direction
//   REQ_ADDR[NREQ*AW]        : per-requester address, slice i = [i*AW +: AW]
//   REQ_WDATA[NREQ*DW]       : per-requester write data
//   DONE[NREQ]               : one-cycle completion pulse (one-hot)
//   RDATA[DW], ERR           : result of the last completed transfer
//   apb (master modport)     : APB bus
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase after
// TIMEOUT_CYC consecutive wait states, completing it with ERR=1, RDATA=0.
// ---------------------------------------------------------------------------
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               SYSCLK,
  input  logic               PRESETN,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    REQ_WRITE,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]    DONE,
  output logic [DW-1:0]      RDATA,
  output logic               ERR,
  apb_master_arbiter_if.master apb
);

  localparam int PW = log2_min1(NREQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   gnt_idx_q;
  logic [NREQ-1:0] gnt_oh_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic            pwrite_q;

  logic [NREQ-1:0] arb_req, arb_grant;
  logic [PW-1:0]   arb_ptr, arb_idx;
  logic            arb_valid;
  logic            complete, abort, finish, load;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = REQ_ADDR[i*AW +: AW];
    assign wdata_arr[i] = REQ_WDATA[i*DW +: DW];
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    if (int'(g) >= NREQ - 1) next_ptr = '0;
    else                     next_ptr = g + PW'(1);
  endfunction

  // During ACCESS we arbitrate for the back-to-back case as if the pointer
  // had already advanced past the current owner, and the owner itself is
  // excluded. A requester still holding REQ in its own DONE cycle is also
  // masked so it cannot be re-granted for a transfer it just finished.
  assign arb_ptr = (state_q == ST_ACCESS) ? next_ptr(gnt_idx_q) : rr_ptr_q;
  assign arb_req = REQ & ~DONE & ((state_q == ST_ACCESS) ? ~gnt_oh_q : '1);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req         (arb_req),
    .ptr         (arb_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign complete = (state_q == ST_ACCESS) && apb.PREADY;
  assign finish   = complete || abort;
  assign load     = (state_d == ST_SETUP);

`ifdef APB_TIMEOUT_EN
  localparam int CW = log2_min1(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt_q;

  // The cycle that would be the TIMEOUT_CYC-th consecutive wait state aborts.
  assign abort = (state_q == ST_ACCESS) && !apb.PREADY &&
                 (tcnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge SYSCLK or negedge PRESETN) begin
    if (!PRESETN)                                    tcnt_q <= '0;
    else if (load)                                   tcnt_q <= '0;
    else if ((state_q == ST_ACCESS) && !apb.PREADY)  tcnt_q <= tcnt_q + CW'(1);
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge SYSCLK or negedge PRESETN) begin
    if (!PRESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (complete)   state_d = arb_valid ? ST_SETUP : ST_IDLE;
        else if (abort) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // PSEL/PENABLE decode straight from the state flop so an async reset
  // drops them in the same cycle.
  always_comb begin
    apb.PSEL    = (state_q != ST_IDLE);
    apb.PENABLE = (state_q == ST_ACCESS);
    apb.PWRITE  = pwrite_q;
    apb.PADDR   = paddr_q;
    apb.PWDATA  = pwdata_q;
  end

  // Fields are captured only at grant; completion results are held until
  // the next completion.
  always_ff @(posedge SYSCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      DONE      <= '0;
      RDATA     <= '0;
      ERR       <= 1'b0;
    end else begin
      DONE <= '0;
      if (finish) begin
        rr_ptr_q <= next_ptr(gnt_idx_q);
        DONE     <= gnt_oh_q;
        RDATA    <= (abort || pwrite_q) ? '0 : apb.PRDATA;
        ERR      <= abort ? 1'b1 : apb.PSLVERR;
      end
      if (load) begin
        gnt_idx_q <= arb_idx;
        gnt_oh_q  <= arb_grant;
        paddr_q   <= addr_arr[arb_idx];
        pwdata_q  <= wdata_arr[arb_idx];
        pwrite_q  <= REQ_WRITE[arb_idx];
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
// Self-checking bench for apb_master_arbiter (NREQ=2, AW=DW=8). Single
// transfers come from a vector table; contention, reset mid-transfer and
// (with APB_TIMEOUT_EN) the timeout abort are hand-written sequences.
// Expected completions go into a scoreboard queue that a DONE monitor pops.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

`ifdef APB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 16;
`endif

  logic        SYSCLK = 1'b0;
  logic        PRESETN;
  logic [1:0]  REQ, REQ_WRITE, DONE;
  logic [15:0] REQ_ADDR, REQ_WDATA;
  logic [7:0]  RDATA;
  logic        ERR;

  apb_master_arbiter_if #(.AW(8), .DW(8)) bus ();

  apb_master_arbiter #(.NREQ(2), .AW(8), .DW(8), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .SYSCLK    (SYSCLK),
    .PRESETN   (PRESETN),
    .REQ       (REQ),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .DONE      (DONE),
    .RDATA     (RDATA),
    .ERR       (ERR),
    .apb       (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    bit         req;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    bit         slverr;
    logic [7:0] expRdata;
    bit         expErr;
  } vec_t;

  typedef struct {
    logic [1:0] done;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  vec_t vecs [6];
  exp_t expQ [$];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic pushExp(input logic [1:0] d, input logic [7:0] r, input logic e);
    exp_t x;
    x.done = d; x.rdata = r; x.err = e;
    expQ.push_back(x);
  endtask

  task automatic setFields(input bit r, input bit wr, input logic [7:0] a,
                           input logic [7:0] wd);
    if (r) begin
      REQ_WRITE[1] = wr; REQ_ADDR[15:8] = a; REQ_WDATA[15:8] = wd;
    end else begin
      REQ_WRITE[0] = wr; REQ_ADDR[7:0] = a; REQ_WDATA[7:0] = wd;
    end
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge SYSCLK) begin
    if (PRESETN === 1'b1 && DONE !== 2'b00) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb_unexpected_done: got %0h expected none at %0t", DONE, $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_done",  32'(DONE),  32'(e.done));
        checkOutput("sb_rdata", 32'(RDATA), 32'(e.rdata));
        checkOutput("sb_err",   32'(ERR),   32'(e.err));
      end
    end
  end

  // One isolated transfer: latency, field capture at grant, stable wait states.
  task automatic applyStimulus(input vec_t v);
    logic [1:0] oh;
    oh = v.req ? 2'b10 : 2'b01;
    pushExp(oh, v.expRdata, v.expErr);
    setFields(v.req, v.wr, v.addr, v.wdata);
    REQ[v.req]  = 1'b1;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = v.prdata;
    bus.PSLVERR = v.slverr;
    tick();
    checkOutput("setup_psel",    32'(bus.PSEL),    32'd1);
    checkOutput("setup_penable", 32'(bus.PENABLE), 32'd0);
    checkOutput("setup_paddr",   32'(bus.PADDR),   32'(v.addr));
    checkOutput("setup_pwrite",  32'(bus.PWRITE),  32'(v.wr));
    if (v.wr) checkOutput("setup_pwdata", 32'(bus.PWDATA), 32'(v.wdata));
    setFields(v.req, ~v.wr, ~v.addr, ~v.wdata);
    tick();
    checkOutput("access_penable", 32'(bus.PENABLE), 32'd1);
    bus.PREADY = (v.waits == 0);
    for (int w = 0; w < v.waits; w++) begin
      tick();
      checkOutput("wait_penable", 32'(bus.PENABLE), 32'd1);
      checkOutput("wait_paddr",   32'(bus.PADDR),   32'(v.addr));
      checkOutput("wait_pwrite",  32'(bus.PWRITE),  32'(v.wr));
      if (v.wr) checkOutput("wait_pwdata", 32'(bus.PWDATA), 32'(v.wdata));
      bus.PREADY = (w == v.waits - 1);
    end
    tick();
    checkOutput("done_latency", 32'(DONE),     32'(oh));
    checkOutput("done_psel",    32'(bus.PSEL), 32'd0);
    REQ[v.req] = 1'b0;
    bus.PREADY = 1'b0;
    tick();
    checkOutput("done_pulse", 32'(DONE), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           req wr addr   wdata  wt prdata slverr expRd  expErr
    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 3, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h44, 8'h00, 1, 8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h45, 8'h00, 0, 8'h77, 1'b0, 8'h77, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h99, 8'h00, 2, 8'hC3, 1'b0, 8'hC3, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h81, 0, 8'hFF, 1'b1, 8'h00, 1'b1};

    PRESETN = 1'b0;
    REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    tick();
    tick();
    checkOutput("rst_psel",    32'(bus.PSEL),    32'd0);
    checkOutput("rst_penable", 32'(bus.PENABLE), 32'd0);
    checkOutput("rst_paddr",   32'(bus.PADDR),   32'd0);
    checkOutput("rst_done",    32'(DONE),        32'd0);
    checkOutput("rst_rdata",   32'(RDATA),       32'd0);
    checkOutput("rst_err",     32'(ERR),         32'd0);
    PRESETN = 1'b1;
    tick();

    $display("[TB] single-transfer vectors");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Pointer now sits at 1; reset during ACCESS of requester 1.
    $display("[TB] reset mid-ACCESS");
    setFields(1'b1, 1'b0, 8'h66, 8'h00);
    REQ = 2'b10;
    tick();
    checkOutput("rma_setup_paddr", 32'(bus.PADDR), 32'h66);
    tick();
    checkOutput("rma_penable", 32'(bus.PENABLE), 32'd1);
    #1;
    PRESETN = 1'b0;
    REQ = 2'b00;
    #1;
    checkOutput("rma_psel_drop",    32'(bus.PSEL),    32'd0);
    checkOutput("rma_penable_drop", 32'(bus.PENABLE), 32'd0);
    tick();
    tick();
    checkOutput("rma_done", 32'(DONE), 32'd0);
    PRESETN = 1'b1;
    setFields(1'b0, 1'b0, 8'h70, 8'h00);
    setFields(1'b1, 1'b0, 8'h71, 8'h00);
    REQ = 2'b11;
    bus.PRDATA = 8'h3E; bus.PSLVERR = 1'b0; bus.PREADY = 1'b1;
    pushExp(2'b01, 8'h3E, 1'b0);
    tick();
    checkOutput("rma_ptr_reset_paddr", 32'(bus.PADDR), 32'h70);
    REQ[1] = 1'b0;
    tick();
    tick();
    checkOutput("rma_done_after", 32'(DONE), 32'd1);
    REQ = 2'b00;
    tick();

    // Both requesters held from reset: 0,1,0,1 with no IDLE gap.
    $display("[TB] contention");
    PRESETN = 1'b0;
    setFields(1'b0, 1'b0, 8'hA0, 8'h00);
    setFields(1'b1, 1'b0, 8'hB1, 8'h00);
    REQ = 2'b11;
    bus.PRDATA = 8'h11; bus.PSLVERR = 1'b0; bus.PREADY = 1'b1;
    tick();
    tick();
    PRESETN = 1'b1;
    pushExp(2'b01, 8'h11, 1'b0);
    pushExp(2'b10, 8'h11, 1'b0);
    pushExp(2'b01, 8'h11, 1'b0);
    pushExp(2'b10, 8'h11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("cont_setup_psel",    32'(bus.PSEL),    32'd1);
      checkOutput("cont_setup_penable", 32'(bus.PENABLE), 32'd0);
      checkOutput("cont_order_paddr",   32'(bus.PADDR),   (i % 2 == 0) ? 32'hA0 : 32'hB1);
      tick();
      checkOutput("cont_access_penable", 32'(bus.PENABLE), 32'd1);
      if (i == 3) REQ = 2'b00;
    end
    tick();
    checkOutput("cont_end_psel", 32'(bus.PSEL), 32'd0);
    bus.PREADY = 1'b0;
    tick();

`ifdef APB_TIMEOUT_EN
    $display("[TB] timeout abort");
    setFields(1'b0, 1'b0, 8'h05, 8'h00);
    bus.PRDATA = 8'h99; bus.PREADY = 1'b0;
    pushExp(2'b01, 8'h00, 1'b1);
    REQ = 2'b01;
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput("to_wait_penable", 32'(bus.PENABLE), 32'd1);
      tick();
    end
    checkOutput("to_abort_psel", 32'(bus.PSEL), 32'd0);
    checkOutput("to_abort_done", 32'(DONE),     32'd1);
    REQ = 2'b00;
    tick();
    applyStimulus(vecs[3]);
`endif

    tick();
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
